led_duty_fader: RTL and testbench

//  Upstream stage of the LED PWM generator. Accepts a target brightness (0-255) via a

---
 rtl/led_duty_fader.sv | 117 +++++++++++
 tb/tb_led_duty_fader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_duty_fader.sv
// led_duty_fader: ramps the PWM duty word toward a requested brightness in
// fixed steps, changing it only at PWM frame boundaries.
module led_duty_fader #(
  parameter int PERIOD          = 256,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tgt_duty,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  output logic [7:0] duty,
  output logic       frame_tick,
  output logic       busy,
  output logic       done
);

  localparam int FCW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [FCW-1:0] F_LAST = FCW'(PERIOD - 1);
  localparam logic [SCW-1:0] S_LAST = SCW'(FRAMES_PER_STEP - 1);
  localparam logic [8:0]     STEP9  = 9'(STEP);
  localparam logic [7:0]     STEP8  = 8'(STEP);

  typedef enum logic {IDLE = 1'b0, FADE = 1'b1} state_t;

  state_t         state;
  logic [FCW-1:0] fcnt;
  logic [SCW-1:0] scnt;
  logic [7:0]     target;
  logic [7:0]     step_duty;
  logic [8:0]     up_gap;
  logic [8:0]     dn_gap;
  logic           accept;

  assign frame_tick = (fcnt == F_LAST);
  assign accept     = tgt_valid & tgt_ready;

  // Gaps are taken in 9 bits so the clamp test can never wrap.
  assign up_gap = {1'b0, target} - {1'b0, duty};
  assign dn_gap = {1'b0, duty} - {1'b0, target};

  // Next duty for a fade step: move by STEP, clamping onto the target.
  always_comb begin
    step_duty = duty;
    if (target > duty)
      step_duty = (up_gap <= STEP9) ? target : duty + STEP8;
    else if (target < duty)
      step_duty = (dn_gap <= STEP9) ? target : duty - STEP8;
  end

  // Free-running frame counter; wraps at PERIOD-1 regardless of state.
  always_ff @(posedge clk) begin
    if (rst)
      fcnt <= '0;
    else if (fcnt == F_LAST)
      fcnt <= '0;
    else
      fcnt <= fcnt + FCW'(1);
  end

  // Fade controller: accepts a target in IDLE, steps duty on frame boundaries in FADE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      duty      <= '0;
      target    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tgt_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            target <= tgt_duty;
            scnt   <= '0;
            if (tgt_duty == duty) begin
              // Already there: acknowledge without ever entering FADE.
              done <= 1'b1;
            end else begin
              state     <= FADE;
              busy      <= 1'b1;
              tgt_ready <= 1'b0;
            end
          end
        end
        FADE: begin
          // Requests are ignored here; tgt_ready is low so nothing is accepted.
          if (frame_tick) begin
            if (scnt == S_LAST) begin
              scnt <= '0;
              duty <= step_duty;
              if (step_duty == target) begin
                state     <= IDLE;
                busy      <= 1'b0;
                tgt_ready <= 1'b1;
                done      <= 1'b1;
              end
            end else begin
              scnt <= scnt + SCW'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          tgt_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_duty_fader.sv
// tb_led_duty_fader: directed tests for led_duty_fader using three parameter
// sets (defaults, STEP=4, STEP=16/FRAMES_PER_STEP=1) sharing clock and reset.
module tb_led_duty_fader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // DUT a: defaults
  logic [7:0] a_tgt = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_ft, a_busy, a_done;
  logic [7:0] a_duty;
  // DUT b: STEP=4
  logic [7:0] b_tgt = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_ft, b_busy, b_done;
  logic [7:0] b_duty;
  // DUT c: STEP=16, FRAMES_PER_STEP=1
  logic [7:0] c_tgt = '0;
  logic       c_valid = 1'b0;
  logic       c_ready, c_ft, c_busy, c_done;
  logic [7:0] c_duty;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  led_duty_fader u_a (
    .clk(clk), .rst(rst), .tgt_duty(a_tgt), .tgt_valid(a_valid), .tgt_ready(a_ready),
    .duty(a_duty), .frame_tick(a_ft), .busy(a_busy), .done(a_done));

  led_duty_fader #(.STEP(4)) u_b (
    .clk(clk), .rst(rst), .tgt_duty(b_tgt), .tgt_valid(b_valid), .tgt_ready(b_ready),
    .duty(b_duty), .frame_tick(b_ft), .busy(b_busy), .done(b_done));

  led_duty_fader #(.STEP(16), .FRAMES_PER_STEP(1)) u_c (
    .clk(clk), .rst(rst), .tgt_duty(c_tgt), .tgt_valid(c_valid), .tgt_ready(c_ready),
    .duty(c_duty), .frame_tick(c_ft), .busy(c_busy), .done(c_done));

  // Advance one clock and land 1 ns after the edge, where inputs change and outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_total++; if (a_duty !== 8'd0) $display("FAIL reset_duty: got %0d want 0", a_duty); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else n_pass++;
    n_total++; if (a_done !== 1'b0) $display("FAIL reset_done: got %b want 0", a_done); else n_pass++;
    n_total++; if (a_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", a_ready); else n_pass++;
    cnt = 0;
    while (a_ft !== 1'b1 && cnt < 1000) begin tick(); cnt++; end
    n_total++; if (cnt != 255) $display("FAIL reset_first_tick: got %0d want 255", cnt); else n_pass++;
    cnt = 0;
    tick(); cnt++;
    while (a_ft !== 1'b1 && cnt < 1000) begin tick(); cnt++; end
    n_total++; if (cnt != 256) $display("FAIL reset_tick_period: got %0d want 256", cnt); else n_pass++;
  endtask

  task automatic test_ramp_up();
    logic [7:0] prev, expd;
    int last, cyc, dones;
    bit pre_ft, ft_bad, spacing_bad, busy_drop, val_bad;
    a_tgt = 8'd8; a_valid = 1'b1; tick(); a_valid = 1'b0;
    n_total++; if (a_busy !== 1'b1) $display("FAIL ramp_busy_rise: got %b want 1", a_busy); else n_pass++;
    n_total++; if (a_ready !== 1'b0) $display("FAIL ramp_ready_low: got %b want 0", a_ready); else n_pass++;
    prev = 8'd0; expd = 8'd1; last = -1; cyc = 0; dones = 0;
    ft_bad = 0; spacing_bad = 0; busy_drop = 0; val_bad = 0;
    while (dones == 0 && cyc < 12000) begin
      pre_ft = a_ft;
      tick(); cyc++;
      if (a_duty !== prev) begin
        if (!pre_ft) ft_bad = 1;
        if (a_duty !== expd) val_bad = 1;
        if (last >= 0 && cyc - last != 1024) spacing_bad = 1;
        if (last < 0 && cyc > 1024) spacing_bad = 1;
        last = cyc; prev = a_duty; expd = expd + 8'd1;
      end
      if (a_done === 1'b1) dones++;
      else if (a_busy !== 1'b1) busy_drop = 1;
    end
    n_total++; if (dones != 1) $display("FAIL ramp_done_seen: got %0d want 1 (cycles %0d)", dones, cyc); else n_pass++;
    n_total++; if (val_bad) $display("FAIL ramp_step_values: got bad sequence want 1..8"); else n_pass++;
    n_total++; if (expd != 8'd9) $display("FAIL ramp_step_count: got %0d want 8", expd - 8'd1); else n_pass++;
    n_total++; if (ft_bad) $display("FAIL ramp_change_on_tick: got change outside frame_tick want none"); else n_pass++;
    n_total++; if (spacing_bad) $display("FAIL ramp_step_spacing: got spacing != 1024 want 1024"); else n_pass++;
    n_total++; if (busy_drop) $display("FAIL ramp_busy_hold: got busy=0 mid-fade want 1"); else n_pass++;
    tick();
    n_total++; if (a_done !== 1'b0) $display("FAIL ramp_done_pulse: got %b want 0", a_done); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL ramp_busy_end: got %b want 0", a_busy); else n_pass++;
    n_total++; if (a_ready !== 1'b1) $display("FAIL ramp_ready_end: got %b want 1", a_ready); else n_pass++;
    n_total++; if (a_duty !== 8'd8) $display("FAIL ramp_final: got %0d want 8", a_duty); else n_pass++;
  endtask

  task automatic test_equal();
    int cyc;
    bit spurious;
    a_tgt = 8'd5; a_valid = 1'b1; tick(); a_valid = 1'b0;
    cyc = 0;
    while (a_done !== 1'b1 && cyc < 6000) begin tick(); cyc++; end
    n_total++; if (a_duty !== 8'd5) $display("FAIL equal_setup: got %0d want 5", a_duty); else n_pass++;
    tick();
    a_tgt = 8'd5; a_valid = 1'b1; tick(); a_valid = 1'b0;
    n_total++; if (a_done !== 1'b1) $display("FAIL equal_done: got %b want 1", a_done); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL equal_busy: got %b want 0", a_busy); else n_pass++;
    n_total++; if (a_ready !== 1'b1) $display("FAIL equal_ready: got %b want 1", a_ready); else n_pass++;
    spurious = 0;
    repeat (20) begin
      tick();
      if (a_done !== 1'b0 || a_busy !== 1'b0 || a_duty !== 8'd5) spurious = 1;
    end
    n_total++; if (spurious) $display("FAIL equal_quiet: got done/busy/duty activity want none"); else n_pass++;
  endtask

  task automatic test_busy_abort();
    int cyc;
    bit done_seen, quiet_bad;
    rst = 1'b1; tick(); rst = 1'b0;
    a_tgt = 8'd10; a_valid = 1'b1; tick(); a_valid = 1'b0;
    done_seen = 0; cyc = 0;
    while (a_duty !== 8'd4 && cyc < 6000) begin
      tick(); cyc++;
      if (a_done === 1'b1) done_seen = 1;
    end
    n_total++; if (a_duty !== 8'd4) $display("FAIL abort_reach4: got %0d want 4", a_duty); else n_pass++;
    a_tgt = 8'd200; a_valid = 1'b1;
    #1;
    n_total++; if (a_ready !== 1'b0) $display("FAIL abort_ready_low: got %b want 0", a_ready); else n_pass++;
    cyc = 0;
    while (a_duty === 8'd4 && cyc < 2000) begin
      tick(); cyc++;
      if (a_done === 1'b1) done_seen = 1;
    end
    a_valid = 1'b0;
    n_total++; if (a_duty !== 8'd5) $display("FAIL abort_continue: got %0d want 5", a_duty); else n_pass++;
    n_total++; if (a_busy !== 1'b1) $display("FAIL abort_busy_mid: got %b want 1", a_busy); else n_pass++;
    rst = 1'b1; tick(); rst = 1'b0;
    n_total++; if (a_duty !== 8'd0) $display("FAIL abort_duty: got %0d want 0", a_duty); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", a_busy); else n_pass++;
    n_total++; if (a_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", a_ready); else n_pass++;
    quiet_bad = 0;
    repeat (2100) begin
      tick();
      if (a_done === 1'b1) done_seen = 1;
      if (a_duty !== 8'd0 || a_busy !== 1'b0) quiet_bad = 1;
    end
    n_total++; if (done_seen) $display("FAIL abort_no_done: got done pulse want none"); else n_pass++;
    n_total++; if (quiet_bad) $display("FAIL abort_quiet: got activity after reset want none"); else n_pass++;
  endtask

  task automatic test_ramp_down();
    int cyc, nchg, dones;
    logic [7:0] prev, v0, v1;
    b_tgt = 8'd10; b_valid = 1'b1; tick(); b_valid = 1'b0;
    cyc = 0;
    while (b_done !== 1'b1 && cyc < 5000) begin tick(); cyc++; end
    n_total++; if (b_duty !== 8'd10) $display("FAIL down_setup: got %0d want 10", b_duty); else n_pass++;
    tick();
    b_tgt = 8'd3; b_valid = 1'b1; tick(); b_valid = 1'b0;
    prev = b_duty; nchg = 0; dones = 0; v0 = '0; v1 = '0;
    repeat (3000) begin
      tick();
      if (b_duty !== prev) begin
        if (nchg == 0) v0 = b_duty;
        if (nchg == 1) v1 = b_duty;
        nchg++; prev = b_duty;
      end
      if (b_done === 1'b1) dones++;
    end
    n_total++; if (nchg != 2) $display("FAIL down_nsteps: got %0d want 2", nchg); else n_pass++;
    n_total++; if (v0 !== 8'd6) $display("FAIL down_step1: got %0d want 6", v0); else n_pass++;
    n_total++; if (v1 !== 8'd3) $display("FAIL down_step2: got %0d want 3", v1); else n_pass++;
    n_total++; if (dones != 1) $display("FAIL down_done: got %0d want 1", dones); else n_pass++;
  endtask

  task automatic test_extremes();
    int nchg, dones, last, cyc;
    bit val_bad, spacing_bad;
    logic [7:0] prev, expd;
    for (int dir = 0; dir < 2; dir++) begin
      c_tgt = (dir == 0) ? 8'd255 : 8'd0;
      c_valid = 1'b1; tick(); c_valid = 1'b0;
      prev = c_duty; nchg = 0; dones = 0; last = -1; cyc = 0;
      val_bad = 0; spacing_bad = 0;
      expd = (dir == 0) ? 8'd16 : 8'd239;
      repeat (4500) begin
        tick(); cyc++;
        if (c_duty !== prev) begin
          if (c_duty !== expd) val_bad = 1;
          if (last >= 0 && cyc - last != 256) spacing_bad = 1;
          last = cyc; prev = c_duty; nchg++;
          if (dir == 0) expd = (prev >= 8'd240) ? 8'd255 : prev + 8'd16;
          else          expd = (prev <= 8'd16)  ? 8'd0   : prev - 8'd16;
        end
        if (c_done === 1'b1) dones++;
      end
      n_total++; if (val_bad) $display("FAIL ext_values_dir%0d: got bad sequence want clamped 16-steps", dir); else n_pass++;
      n_total++; if (nchg != 16) $display("FAIL ext_nsteps_dir%0d: got %0d want 16", dir, nchg); else n_pass++;
      n_total++; if (spacing_bad) $display("FAIL ext_spacing_dir%0d: got spacing != 256 want 256", dir); else n_pass++;
      n_total++; if (dones != 1) $display("FAIL ext_done_dir%0d: got %0d want 1", dir, dones); else n_pass++;
      n_total++; if (c_duty !== ((dir == 0) ? 8'd255 : 8'd0))
        $display("FAIL ext_final_dir%0d: got %0d want %0d", dir, c_duty, (dir == 0) ? 255 : 0); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_equal();
    test_busy_abort();
    test_ramp_down();
    test_extremes();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
